// File: rtl/mult_seq_pkg.sv
// Shared types and defaults for the multiplier operand sequencer.
package mult_seq_pkg;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT   = 3'd3,
    REARM  = 3'd4
  } state_e;
endpackage

// File: rtl/mult_result_reg.sv
// One-entry valid/ready holding register for a product and its error flag.
module mult_result_reg #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic          err_i,
  input  logic [DW-1:0] data_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic          err_o,
  output logic [DW-1:0] data_o
);
  logic          valid_q;
  logic          err_q;
  logic [DW-1:0] data_q;

  // Payload is only written on load; a drain clears valid and leaves stale data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      err_q   <= err_i;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign data_o  = data_q;
endmodule

// File: rtl/mult_op_sequencer.sv
// Feeds operand pairs to a serial shift-add multiplier, waits for done (with
// timeout), re-arms it and hands the product back on a valid/ready port.
module mult_op_sequencer
  import mult_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               mult_reset,
  output logic               mult_start,
  output logic [WIDTH-1:0]   mult_data,
  input  logic [2*WIDTH-1:0] mult_prod,
  input  logic               mult_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic               out_err
);
  localparam int            TW   = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_e           state_q;
  logic [WIDTH-1:0] b_q;
  logic [TW-1:0]    timer_q;
  logic             mult_reset_q;
  logic             mult_start_q;
  logic [WIDTH-1:0] mult_data_q;

  logic               in_wait;
  logic               tmo;
  logic               res_load;
  logic [2*WIDTH-1:0] res_data;

  assign in_wait  = (state_q == WAIT);
  assign tmo      = (timer_q == TMAX);
  // done takes priority over a coincident timeout
  assign res_load = in_wait && (mult_done || tmo);
  assign res_data = mult_done ? mult_prod : '0;
  assign in_ready = (state_q == IDLE) && !out_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      b_q          <= '0;
      timer_q      <= '0;
      mult_reset_q <= 1'b1;
      mult_start_q <= 1'b0;
      mult_data_q  <= '0;
    end else begin
      // mult_reset is a single-cycle pulse; it is only raised on entry to REARM
      mult_reset_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            b_q          <= in_b;
            mult_start_q <= 1'b1;
            mult_data_q  <= in_a;
            state_q      <= SEND_A;
          end
        end
        SEND_A: begin
          mult_start_q <= 1'b0;
          mult_data_q  <= b_q;
          state_q      <= SEND_B;
        end
        SEND_B: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (res_load) begin
            mult_reset_q <= 1'b1;
            mult_data_q  <= '0;
            state_q      <= REARM;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        REARM:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mult_reset = mult_reset_q;
  assign mult_start = mult_start_q;
  assign mult_data  = mult_data_q;

  mult_result_reg #(.DW(2*WIDTH)) u_res (
    .clk     (clk),
    .reset   (reset),
    .load_i  (res_load),
    .err_i   (!mult_done),
    .data_i  (res_data),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .err_o   (out_err),
    .data_o  (out_data)
  );
endmodule

// File: tb/tb_mult_op_sequencer.sv
// Randomized scoreboard bench for mult_op_sequencer with a behavioural multiplier.
module tb_mult_op_sequencer;
  localparam int W    = 8;
  localparam int T    = 32;
  localparam int MLAT = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           out_ready = 1'b1;
  logic           in_ready, mult_reset, mult_start, out_valid, out_err;
  logic [W-1:0]   mult_data;
  logic [2*W-1:0] mult_prod, out_data;
  logic           mult_done;

  mult_op_sequencer #(.WIDTH(W), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mult_reset(mult_reset), .mult_start(mult_start),
    .mult_data(mult_data), .mult_prod(mult_prod), .mult_done(mult_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // multiplier stand-in: A on start, B next cycle, product MLAT cycles later,
  // done held until the next re-arm pulse
  logic       hang = 1'b0;
  logic [W-1:0] m_a, m_b;
  logic       m_ph;
  int         m_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset || mult_reset) begin
      m_a <= '0; m_b <= '0; m_ph <= 1'b0; m_cnt <= 0;
      mult_done <= 1'b0; mult_prod <= '0;
    end else if (mult_start) begin
      m_a <= mult_data; m_ph <= 1'b1;
    end else if (m_ph) begin
      m_b <= mult_data; m_ph <= 1'b0; m_cnt <= MLAT;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !hang) begin
        mult_done <= 1'b1;
        mult_prod <= 16'(m_a) * 16'(m_b);
      end
    end
  end

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: expected {err, product} in issue order
  logic [16:0] exp_q[$];
  int  rx_cnt = 0, n_mrst = 0, ov_cyc = 0, acc_cyc = 0;
  logic ov_prev = 1'b0, rnd_rdy = 1'b0;

  always @(negedge clk) begin
    logic [16:0] e;
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    if (reset) ov_prev = 1'b0;
    else begin
      if (mult_reset) n_mrst++;
      if (out_valid && !ov_prev) ov_cyc = cyc;
      ov_prev = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("result_data", 32'(out_data), 32'(e[15:0]));
          chk("result_err", 32'(out_err), 32'(e[16]));
        end
        rx_cnt++;
      end
    end
  end

  // called at a negedge; returns at the negedge after the accepting edge, in_valid still high
  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int i;
    i = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && i < 300) begin @(negedge clk); i++; end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(hang ? {1'b1, 16'd0} : {1'b0, 16'(a) * 16'(b)});
    @(posedge clk); #1;
    acc_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic wait_rx(input int target);
    int i;
    i = 0;
    while (rx_cnt < target && i < 400) begin @(negedge clk); i++; end
    if (rx_cnt < target) chk("rx_timeout", 32'(rx_cnt), 32'(target));
    @(negedge clk);
  endtask

  initial begin
    int r0, i;
    @(negedge clk);
    chk("rst_mult_reset", 32'(mult_reset), 1);
    chk("rst_mult_start", 32'(mult_start), 0);
    chk("rst_mult_data", 32'(mult_data), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_err", 32'(out_err), 0);
    reset = 1'b0;
    #1 chk("rel_mult_reset_held", 32'(mult_reset), 1);
    @(posedge clk); #1;
    chk("rel_mult_reset_drop", 32'(mult_reset), 0);
    @(negedge clk);

    // 1: 5*3, load protocol and single re-arm pulse
    r0 = n_mrst;
    send_op(5, 3);
    chk("t1_start_a", 32'(mult_start), 1);
    chk("t1_data_a", 32'(mult_data), 5);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_start_b", 32'(mult_start), 0);
    chk("t1_data_b", 32'(mult_data), 3);
    wait_rx(1);
    @(negedge clk);
    chk("t1_rearm_pulses", 32'(n_mrst - r0), 1);

    // 2: back-to-back with in_valid held
    r0 = rx_cnt;
    send_op(7, 4);
    send_op(9, 6);
    chk("t2_first_drained", 32'(rx_cnt), 32'(r0 + 1));
    in_valid = 1'b0;
    wait_rx(r0 + 2);

    // 3: full-range product
    send_op(255, 255);
    in_valid = 1'b0;
    wait_rx(rx_cnt + 1);

    // 4: hung multiplier times out after exactly T cycles in WAIT
    hang = 1'b1;
    r0 = rx_cnt;
    send_op(1, 1);
    in_valid = 1'b0;
    wait_rx(r0 + 1);
    chk("t4_timeout_cycles", 32'(ov_cyc - acc_cyc), 32'(T + 2));
    hang = 1'b0;
    send_op(2, 3);
    in_valid = 1'b0;
    wait_rx(r0 + 2);

    // 5: backpressure holds the result stable
    out_ready = 1'b0;
    send_op(6, 7);
    in_valid = 1'b0;
    i = 0;
    while (!out_valid && i < 200) begin @(negedge clk); i++; end
    chk("t5_result_seen", 32'(out_valid), 1);
    for (int k = 0; k < 10; k++) begin
      chk("t5_hold_valid", 32'(out_valid), 1);
      chk("t5_hold_data", 32'(out_data), 42);
      chk("t5_in_ready_low", 32'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_rx(rx_cnt + 1);

    // 6: reset during WAIT drops the op
    send_op(8, 8);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_mult_reset", 32'(mult_reset), 1);
    chk("t6_mult_start", 32'(mult_start), 0);
    chk("t6_mult_data", 32'(mult_data), 0);
    chk("t6_out_valid", 32'(out_valid), 0);
    chk("t6_out_data", 32'(out_data), 0);
    chk("t6_out_err", 32'(out_err), 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    r0 = rx_cnt;
    send_op(4, 4);
    in_valid = 1'b0;
    wait_rx(r0 + 1);

    // random operands under random backpressure
    rnd_rdy = 1'b1;
    r0 = rx_cnt;
    for (int k = 0; k < 25; k++) begin
      send_op(W'($urandom), W'($urandom));
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_rx(r0 + 25);
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
